// File: rtl/fp_div_seq_if.sv
// Handshake and data bundle between the execute-stage issue logic and the
// sequential single-precision divider.
interface fp_div_seq_if;
  logic        start;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;
  logic        invalid;

  modport master (
    output start, op1, op2,
    input  busy, done, result, div_by_zero, invalid
  );

  modport slave (
    input  start, op1, op2,
    output busy, done, result, div_by_zero, invalid
  );
endinterface

// File: rtl/fp_div_seq.sv
// Multi-cycle IEEE-754 single-precision divider: restoring division, one
// quotient bit per clock, round-to-nearest-even, subnormals flushed to zero.
module fp_div_seq (
  input  logic        clk,
  input  logic        rst,
  fp_div_seq_if.slave bus
);
  localparam int QBITS = 27;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] ROUND  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]        state;
  logic [4:0]        cnt;
  logic              sign;
  logic signed [9:0] e;
  logic [23:0]       sb;
  logic [25:0]       rem;
  logic [QBITS-1:0]  q;
  logic [31:0]       res;
  logic              dz;
  logic              inv;

  assign bus.busy        = (state == DIVIDE) || (state == ROUND);
  assign bus.done        = (state == DONE);
  assign bus.result      = res;
  assign bus.div_by_zero = dz;
  assign bus.invalid     = inv;

  // Operand classification on the live inputs; only consumed in IDLE.
  logic [7:0]  ea, eb;
  logic        za, zb, na, nb, ia, ib;
  logic        special, sgn_in;
  logic [31:0] spec_res;
  logic        spec_dz, spec_inv;

  always_comb begin
    ea       = bus.op1[30:23];
    eb       = bus.op2[30:23];
    sgn_in   = bus.op1[31] ^ bus.op2[31];
    za       = (ea == 8'd0);
    zb       = (eb == 8'd0);
    na       = (ea == 8'hFF) && (bus.op1[22:0] != 23'd0);
    nb       = (eb == 8'hFF) && (bus.op2[22:0] != 23'd0);
    ia       = (ea == 8'hFF) && (bus.op1[22:0] == 23'd0);
    ib       = (eb == 8'hFF) && (bus.op2[22:0] == 23'd0);
    special  = za | zb | na | nb | ia | ib;
    spec_res = {sgn_in, 31'd0};
    spec_dz  = 1'b0;
    spec_inv = 1'b0;
    if (na || nb) begin
      spec_res = 32'h7FC0_0000;
      spec_inv = 1'b1;
    end else if ((za && zb) || (ia && ib)) begin
      spec_res = 32'h7FC0_0000;
      spec_inv = 1'b1;
    end else if (zb) begin
      spec_res = {sgn_in, 8'hFF, 23'd0};
      spec_dz  = !ia;
    end else if (ia) begin
      spec_res = {sgn_in, 8'hFF, 23'd0};
    end
  end

  // One restoring step. The accepting edge performs the first step straight
  // from the inputs so that all QBITS bits are in q when DIVIDE ends.
  logic [25:0] step_rem;
  logic [23:0] step_sb;
  logic        step_bit;
  logic [25:0] step_diff;
  logic [25:0] step_next;

  always_comb begin
    step_rem  = (state == IDLE) ? {2'b00, 1'b1, bus.op1[22:0]} : rem;
    step_sb   = (state == IDLE) ? {1'b1, bus.op2[22:0]} : sb;
    step_bit  = (step_rem >= {2'b00, step_sb});
    step_diff = step_bit ? (step_rem - {2'b00, step_sb}) : step_rem;
    step_next = step_diff << 1;
  end

  // Normalise, round to nearest even, then range-check the exponent.
  logic [23:0]       m0;
  logic              g, r, s, round_up;
  logic signed [9:0] e_adj, e_rnd;
  logic [24:0]       m_inc;
  logic [22:0]       m_frac;
  logic [31:0]       rnd_res;

  always_comb begin
    if (q[26]) begin
      m0    = q[26:3];
      g     = q[2];
      r     = q[1];
      s     = q[0] | (rem != 26'd0);
      e_adj = e;
    end else begin
      m0    = q[25:2];
      g     = q[1];
      r     = q[0];
      s     = (rem != 26'd0);
      e_adj = e - 10'sd1;
    end
    round_up = g & (r | s | m0[0]);
    m_inc    = {1'b0, m0} + {24'd0, round_up};
    e_rnd    = m_inc[24] ? (e_adj + 10'sd1) : e_adj;
    m_frac   = m_inc[24] ? m_inc[23:1] : m_inc[22:0];
    if (e_rnd >= 10'sd255)
      rnd_res = {sign, 8'hFF, 23'd0};
    else if (e_rnd <= 10'sd0)
      rnd_res = {sign, 31'd0};
    else
      rnd_res = {sign, e_rnd[7:0], m_frac};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
      sign  <= 1'b0;
      e     <= 10'sd0;
      sb    <= 24'd0;
      rem   <= 26'd0;
      q     <= '0;
      res   <= 32'd0;
      dz    <= 1'b0;
      inv   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign <= sgn_in;
            dz   <= 1'b0;
            inv  <= 1'b0;
            if (special) begin
              res   <= spec_res;
              dz    <= spec_dz;
              inv   <= spec_inv;
              state <= DONE;
            end else begin
              e     <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
              sb    <= {1'b1, bus.op2[22:0]};
              rem   <= step_next;
              q     <= {{(QBITS-1){1'b0}}, step_bit};
              cnt   <= 5'd0;
              state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem <= step_next;
          q   <= {q[QBITS-2:0], step_bit};
          cnt <= cnt + 5'd1;
          if (cnt == 5'(QBITS - 2))
            state <= ROUND;
        end
        ROUND: begin
          res   <= rnd_res;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed corner cases plus randomized
// operands checked against an integer long-division reference model.
module tb_fp_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fp_div_seq_if bus();

  fp_div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: whole quotient from one wide integer divide, then RNE by
  // comparing the discarded bits against one half.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic dz,
                                  output logic inv, output logic spec);
    int ea, eb, ex, sh;
    logic sg, za, zb, na, nb, ia, ib;
    longint unsigned n, d, qq, rr, m, low, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sg = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    spec = za | zb | na | nb | ia | ib;
    dz = 1'b0;
    inv = 1'b0;
    res = {sg, 31'd0};
    if (na || nb) begin
      res = 32'h7FC00000; inv = 1'b1;
    end else if ((za && zb) || (ia && ib)) begin
      res = 32'h7FC00000; inv = 1'b1;
    end else if (zb) begin
      res = {sg, 8'hFF, 23'd0}; dz = !ia;
    end else if (ia) begin
      res = {sg, 8'hFF, 23'd0};
    end else if (!(za || ib)) begin
      n  = 64'(8388608 + int'(a[22:0]));
      d  = 64'(8388608 + int'(b[22:0]));
      qq = (n << 40) / d;
      rr = (n << 40) % d;
      ex = ea - eb + 127;
      if (n >= d) sh = 17;
      else begin sh = 16; ex = ex - 1; end
      m    = qq >> sh;
      low  = qq & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (low > half || (low == half && (rr != 0 || m[0])))
        m = m + 1;
      if (m == 64'd16777216) begin
        m = m >> 1; ex = ex + 1;
      end
      if (ex >= 255)     res = {sg, 8'hFF, 23'd0};
      else if (ex <= 0)  res = {sg, 31'd0};
      else               res = {sg, 8'(ex), m[22:0]};
    end
  endfunction

  // One transaction from IDLE; ends one cycle after done so the next call
  // starts in the cycle after done.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eres, input logic edz, input logic einv,
                        input int elat);
    int lat, busy_cyc;
    logic seen;
    bus.op1 = a;
    bus.op2 = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.op1 = $urandom;
    bus.op2 = $urandom;
    lat = 1;
    busy_cyc = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_cyc++;
      tick();
      lat++;
    end
    seen = bus.done;
    chk({tag, ".done_seen"}, 32'(seen), 32'd1);
    chk({tag, ".latency"}, 32'(lat), 32'(elat));
    chk({tag, ".busy_cycles"}, 32'(busy_cyc), 32'(elat - 1));
    chk({tag, ".result"}, bus.result, eres);
    chk({tag, ".div_by_zero"}, 32'(bus.div_by_zero), 32'(edz));
    chk({tag, ".invalid"}, 32'(bus.invalid), 32'(einv));
    tick();
    chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  function automatic logic [31:0] gen_op();
    logic [31:0] v;
    int cls;
    v = $urandom;
    cls = $urandom_range(0, 15);
    case (cls)
      0: v[30:23] = 8'd0;
      1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      2: begin v[30:23] = 8'hFF; v[0] = 1'b1; end
      3: v[30:23] = 8'($urandom_range(1, 254));
      4: begin v[30:23] = 8'($urandom_range(110, 144)); v[22:0] = 23'd0; end
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] a, b, er;
    logic edz, einv, esp;
    int dcount, d1c, d2c;
    logic [31:0] d1r, d2r;

    bus.start = 1'b0;
    bus.op1 = 32'd0;
    bus.op2 = 32'd0;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.result", bus.result, 32'd0);
    chk("reset.dz", 32'(bus.div_by_zero), 32'd0);
    chk("reset.inv", 32'(bus.invalid), 32'd0);
    rst = 1'b0;
    tick();

    run_op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 28);
    run_op("one_third",  32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 28);
    run_op("one_by_one", 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 28);
    run_op("neg_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1'b0, 1);
    run_op("zero_zero",  32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1, 1);
    run_op("inf_by_two", 32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 1'b0, 1);
    run_op("overflow",   32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 1'b0, 28);
    run_op("underflow",  32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b0, 28);
    run_op("inf_inf",    32'hFF800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b1, 1);
    run_op("x_by_inf",   32'h40000000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0, 1);
    run_op("nan_in",     32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 1);
    run_op("inf_by_zero", 32'h7F800000, 32'h80000000, 32'hFF800000, 1'b0, 1'b0, 1);

    // start held for 40 cycles; op1 changes mid-divide
    bus.op1 = 32'h40C00000;
    bus.op2 = 32'h40000000;
    bus.start = 1'b1;
    dcount = 0; d1c = -1; d2c = -1; d1r = 32'd0; d2r = 32'd0;
    for (int i = 1; i <= 65; i++) begin
      tick();
      if (i == 5) bus.op1 = 32'h3F800000;
      if (i == 40) bus.start = 1'b0;
      if (bus.done) begin
        dcount++;
        if (dcount == 1) begin d1c = i; d1r = bus.result; end
        else if (dcount == 2) begin d2c = i; d2r = bus.result; end
      end
    end
    chk("held.done_count", 32'(dcount), 32'd2);
    chk("held.first_cycle", 32'(d1c), 32'd28);
    chk("held.first_result", d1r, 32'h40400000);
    chk("held.second_cycle", 32'(d2c), 32'd57);
    chk("held.second_result", d2r, 32'h3F000000);

    // reset in the middle of a divide
    bus.op1 = 32'h40C00000;
    bus.op2 = 32'h40000000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.result", bus.result, 32'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) dcount++;
      tick();
    end
    chk("abort.no_done", 32'(dcount), 32'd0);
    run_op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 28);

    for (int k = 0; k < 200; k++) begin
      a = gen_op();
      b = gen_op();
      ref_div(a, b, er, edz, einv, esp);
      run_op($sformatf("rand%0d", k), a, b, er, edz, einv, esp ? 1 : 28);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
